// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM front-end: FSM states, requester ids
// and default bus widths.
package sram_ctrl_pkg;

    localparam int DEF_ADDR_SIZE = 18;
    localparam int DEF_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/sram_ctrl_if.sv
// Requester and SRAM-side signal bundle for sram_ctrl; the controller uses the
// slave view, the environment (requesters plus SRAM device) the master view.
interface sram_ctrl_if #(
    parameter int dAddrSize = sram_ctrl_pkg::DEF_ADDR_SIZE,
    parameter int dWordSize = sram_ctrl_pkg::DEF_WORD_SIZE
) ();

    logic                 cReqA;
    logic                 cWrA;
    logic [dAddrSize-1:0] vAddrA;
    logic [dWordSize-1:0] vWDataA;
    logic                 cDoneA;

    logic                 cReqB;
    logic                 cWrB;
    logic [dAddrSize-1:0] vAddrB;
    logic [dWordSize-1:0] vWDataB;
    logic                 cDoneB;

    logic [dWordSize-1:0] vRData;
    logic                 cBusy;

    logic [dAddrSize-1:0] vSramAddr;
    logic [dWordSize-1:0] vSramInData;
    logic [dWordSize-1:0] vSramOutData;
    logic                 cSramCE;
    logic                 cSramWE;

    modport slave (
        input  cReqA, cWrA, vAddrA, vWDataA,
        input  cReqB, cWrB, vAddrB, vWDataB,
        input  vSramOutData,
        output cDoneA, cDoneB, vRData, cBusy,
        output vSramAddr, vSramInData, cSramCE, cSramWE
    );

    modport master (
        output cReqA, cWrA, vAddrA, vWDataA,
        output cReqB, cWrB, vAddrB, vWDataB,
        output vSramOutData,
        input  cDoneA, cDoneB, vRData, cBusy,
        input  vSramAddr, vSramInData, cSramCE, cSramWE
    );

endinterface

// File: rtl/sram_rr_arb.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to the
// requester that was not granted last. The pointer moves only on i_take.
module sram_rr_arb
    import sram_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_take,
    output logic o_gnt_id,
    output logic o_gnt_vld
);

    logic r_prio;  // requester favoured on the next tie

    // NOTE: every output of a combinational block gets a default first so no
    // path through the branches can leave it unassigned and infer a latch.
    always_comb begin
        o_gnt_vld = i_req_a | i_req_b;
        o_gnt_id  = REQ_A;
        if (i_req_a && i_req_b) begin
            o_gnt_id = r_prio;
        end else if (i_req_b) begin
            o_gnt_id = REQ_B;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio <= REQ_A;
        end else if (i_take && o_gnt_vld) begin
            r_prio <= ~o_gnt_id;
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous front-end for an asynchronous SRAM: arbitrates two requesters and
// runs each access as SETUP, STROBE (dStrobeCyc cycles), HOLD with registered CE/WE.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int dAddrSize  = DEF_ADDR_SIZE,
    parameter int dWordSize  = DEF_WORD_SIZE,
    parameter int dStrobeCyc = 2            // must be >= 1
) (
    input  logic       cClk,
    input  logic       cRst_n,
    sram_ctrl_if.slave bus
);

    localparam int               CNT_W    = (dStrobeCyc > 1) ? $clog2(dStrobeCyc) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(dStrobeCyc - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_id;
    logic                 r_wr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ce;
    logic                 r_we;
    logic [dAddrSize-1:0] r_addr;
    logic [dWordSize-1:0] r_wdata;
    logic [dWordSize-1:0] r_rdata;

    logic                 w_gnt_id;
    logic                 w_gnt_vld;
    logic                 w_take;
    logic                 w_win_wr;
    logic [dAddrSize-1:0] w_win_addr;
    logic [dWordSize-1:0] w_win_wdata;
    logic                 w_wr_nxt;
    logic                 w_ce_nxt;
    logic                 w_we_nxt;
    logic                 w_last_strobe;

    sram_rr_arb u_arb (
        .i_clk     (cClk),
        .i_rst_n   (cRst_n),
        .i_req_a   (bus.cReqA),
        .i_req_b   (bus.cReqB),
        .i_take    (w_take),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_vld (w_gnt_vld)
    );

    assign w_win_wr      = (w_gnt_id == REQ_B) ? bus.cWrB    : bus.cWrA;
    assign w_win_addr    = (w_gnt_id == REQ_B) ? bus.vAddrB  : bus.vAddrA;
    assign w_win_wdata   = (w_gnt_id == REQ_B) ? bus.vWDataB : bus.vWDataA;
    assign w_last_strobe = (r_state == STROBE) && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_take      = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP:   w_state_nxt = STROBE;
            STROBE:  if (r_cnt == '0) w_state_nxt = HOLD;
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // CE/WE are computed from the next state and registered, so the write
    // strobe brackets CE on both sides and neither pin can glitch.
    assign w_wr_nxt = w_take ? w_win_wr : r_wr;
    assign w_ce_nxt = (w_state_nxt != STROBE);
    assign w_we_nxt = !((w_state_nxt != IDLE) && w_wr_nxt);

    always_ff @(posedge cClk or negedge cRst_n) begin
        if (!cRst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge cClk or negedge cRst_n) begin
        if (!cRst_n) begin
            r_id    <= REQ_A;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
            r_ce    <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_ce <= w_ce_nxt;
            r_we <= w_we_nxt;
            if (w_take) begin
                r_id    <= w_gnt_id;
                r_wr    <= w_win_wr;
                r_addr  <= w_win_addr;
                r_wdata <= w_win_wdata;
            end
            if (r_state == SETUP) begin
                r_cnt <= CNT_LAST;
            end else if ((r_state == STROBE) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_last_strobe && !r_wr) begin
                r_rdata <= bus.vSramOutData;
            end
        end
    end

    assign bus.vSramAddr   = r_addr;
    assign bus.vSramInData = r_wdata;
    assign bus.cSramCE     = r_ce;
    assign bus.cSramWE     = r_we;
    assign bus.vRData      = r_rdata;
    assign bus.cBusy       = (r_state != IDLE);
    assign bus.cDoneA      = (r_state == HOLD) && (r_id == REQ_A);
    assign bus.cDoneB      = (r_state == HOLD) && (r_id == REQ_B);

endmodule
